mips150_io_regs: RTL

Memory-mapped I/O register block for the MIPS150 three-stage pipeline. It sits beside DMEM on the X/M boundary and is addressed when the memory map routes a load or store to I/O space. It accepts the X-stage address, byte store mask and store data, and returns load data registered into the M stage, replacing the fixed I/O load value. It also bridges to a byte-wide UART through a TX holding register and a 4-entry RX FIFO, and optionally provides cycle and instruction counters.

---
 rtl/mips150_io_pkg.sv | 20 ++
 rtl/io_rx_fifo.sv | 53 +++++
 rtl/mips150_io_regs.sv | 121 ++++++++++++
 3 files changed

// File: rtl/mips150_io_pkg.sv
// Shared definitions for the MIPS150 memory-mapped I/O register block:
// word offsets within I/O space and the UART byte width.
package mips150_io_pkg;

    localparam int UART_W = 8;

    localparam logic [7:0] IO_TX_STAT = 8'h00;
    localparam logic [7:0] IO_RX_STAT = 8'h04;
    localparam logic [7:0] IO_RX_DATA = 8'h08;
    localparam logic [7:0] IO_TX_DATA = 8'h0C;
    localparam logic [7:0] IO_CYC_CNT = 8'h10;
    localparam logic [7:0] IO_INS_CNT = 8'h14;
    localparam logic [7:0] IO_CNT_CLR = 8'h18;

    // Byte address -> word-aligned offset; the two byte-select bits never matter here.
    function automatic logic [7:0] io_word_off(input logic [7:0] addr);
        return addr & 8'hFC;
    endfunction

endpackage

// File: rtl/io_rx_fifo.sv
// Small synchronous FIFO buffering received UART bytes until software reads them.
// DEPTH must be a power of two (and at least 2) so the pointers wrap naturally.
module io_rx_fifo
    import mips150_io_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = UART_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_head,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push  = i_push && (r_count != (AW+1)'(DEPTH));
    assign w_pop   = i_pop && (r_count != '0);
    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    // NOTE: the storage array is deliberately not reset; r_count alone says which entries are valid.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_push_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/mips150_io_regs.sv
// MIPS150 memory-mapped I/O registers: UART TX holding register, RX FIFO and,
// when IO_COUNTERS_EN is defined, cycle/instruction counters. Load data is registered into M.
module mips150_io_regs
    import mips150_io_pkg::*;
#(
    parameter int RX_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        io_addr,
    input  logic [3:0]        io_store_mask,
    input  logic [31:0]       io_wdata,
    input  logic              io_load,
    output logic [31:0]       io_rdata,
    input  logic              instr_retire,
    output logic [UART_W-1:0] uart_tx_data,
    output logic              uart_tx_valid,
    input  logic              uart_tx_ready,
    input  logic [UART_W-1:0] uart_rx_data,
    input  logic              uart_rx_valid,
    output logic              uart_rx_ready
);

    localparam int CW = $clog2(RX_DEPTH) + 1;

    logic [7:0]        w_off;
    logic [UART_W-1:0] w_rx_head;
    logic [CW-1:0]     w_rx_count;
    logic              w_rx_nonempty;
    logic              w_rx_push;
    logic              w_rx_pop;
    logic              w_tx_write;
    logic [31:0]       w_rdata_next;
    logic [31:0]       w_cyc_cnt;
    logic [31:0]       w_ins_cnt;

    logic [31:0]       r_rdata;
    logic              r_tx_valid;
    logic [UART_W-1:0] r_tx_data;

    assign w_off         = io_word_off(io_addr);
    assign w_rx_nonempty = (w_rx_count != '0);
    assign uart_rx_ready = ~rst & (w_rx_count != CW'(RX_DEPTH));
    assign w_rx_push     = uart_rx_valid & uart_rx_ready;
    assign w_rx_pop      = io_load && (w_off == IO_RX_DATA) && w_rx_nonempty;
    assign w_tx_write    = io_store_mask[0] && (w_off == IO_TX_DATA);

    io_rx_fifo #(
        .DEPTH (RX_DEPTH),
        .WIDTH (UART_W)
    ) u_rx_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_rx_push),
        .i_push_data (uart_rx_data),
        .i_pop       (w_rx_pop),
        .o_head      (w_rx_head),
        .o_count     (w_rx_count)
    );

`ifdef IO_COUNTERS_EN
    logic [31:0] r_cyc_cnt;
    logic [31:0] r_ins_cnt;
    logic        w_cnt_clr;

    assign w_cnt_clr = (|io_store_mask) && (w_off == IO_CNT_CLR);

    // Clear wins over the same-cycle increment.
    always_ff @(posedge clk) begin
        if (rst || w_cnt_clr) begin
            r_cyc_cnt <= '0;
            r_ins_cnt <= '0;
        end else begin
            r_cyc_cnt <= r_cyc_cnt + 32'd1;
            if (instr_retire) r_ins_cnt <= r_ins_cnt + 32'd1;
        end
    end

    assign w_cyc_cnt = r_cyc_cnt;
    assign w_ins_cnt = r_ins_cnt;
`else
    assign w_cyc_cnt = '0;
    assign w_ins_cnt = '0;
`endif

    // NOTE: defaulting the output first means no path through the case leaves it unassigned, so no latch.
    always_comb begin
        w_rdata_next = '0;
        case (w_off)
            IO_TX_STAT: w_rdata_next = {31'b0, ~r_tx_valid};
            IO_RX_STAT: w_rdata_next = {31'b0, w_rx_nonempty};
            IO_RX_DATA: w_rdata_next = w_rx_nonempty ? 32'(w_rx_head) : 32'd0;
            IO_CYC_CNT: w_rdata_next = w_cyc_cnt;
            IO_INS_CNT: w_rdata_next = w_ins_cnt;
            default:    w_rdata_next = '0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata    <= '0;
            r_tx_valid <= 1'b0;
            r_tx_data  <= '0;
        end else begin
            if (io_load) r_rdata <= w_rdata_next;
            // A write while a byte is still pending is dropped.
            if (r_tx_valid && uart_tx_ready) begin
                r_tx_valid <= 1'b0;
            end else if (!r_tx_valid && w_tx_write) begin
                r_tx_valid <= 1'b1;
                r_tx_data  <= io_wdata[UART_W-1:0];
            end
        end
    end

    assign io_rdata      = r_rdata;
    assign uart_tx_valid = r_tx_valid;
    assign uart_tx_data  = r_tx_data;

endmodule
